// File: rtl/pipe_reg_if.sv
// Valid/ready bus for pipe_reg: the upstream (in_*) and downstream (out_*) handshakes.
// slave is the pipeline's view; master is the driver/monitor view.
interface pipe_reg_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/pipe_reg.sv
// DEPTH-stage valid/ready register pipeline with bubble collapse and synchronous flush.
// Define PIPE_REG_CNT_EN to add the registered occupancy output 'count'.
module pipe_reg_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             ld,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v,
  output logic [WIDTH-1:0] d
);
  // Flush drops the valid bit but leaves the data register untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= 1'b0;
      d <= '0;
    end else begin
      if (flush)   v <= 1'b0;
      else if (ld) v <= v_in;
      if (ld && v_in && !flush) d <= d_in;
    end
  end
endmodule

module pipe_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  pipe_reg_if.slave    bus
`ifdef PIPE_REG_CNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count
`endif
);
  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;
  logic [DEPTH:0]              rdy;

  // A stage can load if it is empty or everything downstream of it moves.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--)
      rdy[i] = ~vld_pipe[i] | rdy[i+1];
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      pipe_reg_stage #(.WIDTH(WIDTH)) u_stage (
        .clk(clk), .rst(rst), .flush(flush), .ld(rdy[g]),
        .v_in(bus.in_valid), .d_in(bus.in_data),
        .v(vld_pipe[g]), .d(dat_pipe[g])
      );
    end else begin : g_body
      pipe_reg_stage #(.WIDTH(WIDTH)) u_stage (
        .clk(clk), .rst(rst), .flush(flush), .ld(rdy[g]),
        .v_in(vld_pipe[g-1]), .d_in(dat_pipe[g-1]),
        .v(vld_pipe[g]), .d(dat_pipe[g])
      );
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld_pipe[DEPTH-1];
  assign bus.out_data  = dat_pipe[DEPTH-1];

`ifdef PIPE_REG_CNT_EN
  localparam int CW = $clog2(DEPTH + 1);
  logic in_xfer, out_xfer;

  // Internal moves never change occupancy; only the two end transfers do.
  assign in_xfer  = bus.in_valid & rdy[0];
  assign out_xfer = vld_pipe[DEPTH-1] & bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       count <= '0;
    else if (flush) count <= '0;
    else            count <= count + CW'(in_xfer) - CW'(out_xfer);
  end
`endif
endmodule

// File: tb/tb_pipe_reg.sv
// Directed bench for pipe_reg (WIDTH=8, DEPTH=4): stimulus queues expected items,
// a negedge monitor pops and compares every output transfer.
module tb_pipe_reg;
  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  pipe_reg_if #(.WIDTH(W)) bus ();
`ifdef PIPE_REG_CNT_EN
  logic [$clog2(D+1)-1:0] count;
`endif

  pipe_reg #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
`ifdef PIPE_REG_CNT_EN
    , .count(count)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every output transfer must match the head of the queue.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_unexpected: got %0h, expected no output", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok_rdy, ok_vld;

    // Reset held with input activity
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hAA;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data",  32'(bus.out_data),  0);
`ifdef PIPE_REG_CNT_EN
    chk("rst_count", 32'(count), 0);
`endif
    step();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // Latency: one item, four-edge path
    step();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    exp_q.push_back(8'h11);
    step();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("lat_valid_e%0d", k), 32'(bus.out_valid), 32'(k == 3));
      if (k == 3) chk("lat_data", 32'(bus.out_data), 32'h11);
    end

    // Backpressure: fill to four, fifth refused, then drain in order
    step();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      @(negedge clk);
      chk($sformatf("bp_in_ready_%0d", i), 32'(bus.in_ready), 32'(i <= 4));
      if (i <= 4) exp_q.push_back(8'(i));
      if (i < 5) step();
    end
`ifdef PIPE_REG_CNT_EN
    chk("bp_count_full", 32'(count), 4);
`endif
    step();
    bus.out_ready = 1'b1;
    exp_q.push_back(8'h05);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_drain_valid_%0d", k), 32'(bus.out_valid), 1);
      step();
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    chk("bp_drained_valid", 32'(bus.out_valid), 0);
    chk("bp_queue_empty", 32'(exp_q.size()), 0);

    // Streaming: 100 back-to-back items
    step();
    ok_rdy = 1'b1;
    ok_vld = 1'b1;
    for (int i = 0; i < 104; i++) begin
      bus.in_valid = (i < 100);
      bus.in_data  = 8'(i);
      if (i < 100) exp_q.push_back(8'(i));
      @(negedge clk);
      if (i < 100 && !bus.in_ready) ok_rdy = 1'b0;
      if (bus.out_valid != (i >= 4)) ok_vld = 1'b0;
      step();
    end
    bus.in_valid = 1'b0;
    chk("stream_in_ready_steady", 32'(ok_rdy), 1);
    chk("stream_out_consecutive", 32'(ok_vld), 1);
    chk("stream_queue_empty", 32'(exp_q.size()), 0);

    // Flush on a full pipe with simultaneous input and output transfers
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      exp_q.push_back(8'(i));
      step();
    end
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h55;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("fl_in_ready", 32'(bus.in_ready), 1);
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_head_taken", 32'(exp_q.size()), 3);
    exp_q.delete();
    @(negedge clk);
    chk("fl_out_valid", 32'(bus.out_valid), 0);
`ifdef PIPE_REG_CNT_EN
    chk("fl_count", 32'(count), 0);
`endif
    ok_vld = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) ok_vld = 1'b0;
    end
    chk("fl_nothing_emerges", 32'(ok_vld), 1);

    // Asynchronous reset with three items held
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = (i < 3);
      bus.in_data  = 8'(8'hA1 + i);
      if (i < 3) exp_q.push_back(8'(8'hA1 + i));
      step();
    end
    chk("ar_pre_valid", 32'(bus.out_valid), 1);
`ifdef PIPE_REG_CNT_EN
    chk("ar_pre_count", 32'(count), 3);
`endif
    #1 rst = 1'b0;
    #1;
    chk("ar_out_valid", 32'(bus.out_valid), 0);
    chk("ar_out_data",  32'(bus.out_data),  0);
`ifdef PIPE_REG_CNT_EN
    chk("ar_count", 32'(count), 0);
`endif
    #1 rst = 1'b1;
    exp_q.delete();
    bus.out_ready = 1'b1;
    ok_vld = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) ok_vld = 1'b0;
    end
    chk("ar_nothing_emerges", 32'(ok_vld), 1);
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 4: number of register stages, legal range 1..16.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream data valid.
REQ-006 in_data  input  WIDTH  upstream data.
REQ-007 in_ready  output  1  block can accept in_data this cycle.
REQ-008 out_valid  output  1  out_data holds a valid item.
REQ-009 out_data  output  WIDTH  data from the last stage.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 flush  input  1  synchronous clear of all stage valid bits.
REQ-012 count  output  $clog2(DEPTH+1)  number of occupied stages; present only under PIPE_REG_CNT_EN.

Function
REQ-013 The block SHALL hold stages s[0..DEPTH-1], each with one valid bit and one WIDTH data register; s[0] is the input stage and s[DEPTH-1] drives out_valid and out_data directly from registers.
REQ-014 Stage ready rule SHALL be: ready[DEPTH]=out_ready; ready[i] = !v[i] | ready[i+1]; stage i loads from stage i-1 (or from in_data for i=0) on each edge where ready[i]=1.
REQ-015 in_ready SHALL equal ready[0], a combinational function of out_ready and the valid bits only, never of in_valid.
REQ-016 An input transfer occurs on an edge with in_valid=1 and in_ready=1; an output transfer occurs on an edge with out_valid=1 and out_ready=1.
REQ-017 When a stage loads and the feeding stage is empty (or in_valid=0 for s[0]), its valid bit SHALL clear; its data register SHALL be loaded only when incoming valid=1.
REQ-018 With no stall, an item accepted on edge n SHALL be presented with out_valid=1 after edge n+DEPTH-1; this gives DEPTH-cycle latency, and DEPTH=1 presents it after edge n.
REQ-019 Sustained throughput SHALL be one item per cycle when in_valid=1 and out_ready=1 continuously.
REQ-020 Bubbles SHALL collapse: with out_ready=0, items advance into empty downstream stages until all DEPTH stages are full, then in_ready=0.
REQ-021 Items SHALL leave in acceptance order with no loss or duplication.
REQ-022 flush=1 at an edge SHALL clear every valid bit, and the data registers SHALL keep their values.
REQ-023 An input transfer at a flush edge SHALL be discarded.
REQ-024 An output transfer at a flush edge SHALL still count as completed.

Reset
REQ-025 While rst=0, every valid bit, every stage data register, out_valid, out_data and count SHALL be 0, independent of clk.
REQ-026 After rst releases, in_ready SHALL be 1 in the first cycle.
REQ-027 Assertion of rst mid-stream SHALL discard all held items immediately.

Configuration
REQ-028 With macro PIPE_REG_CNT_EN defined, output count SHALL exist and equal the number of set valid bits, registered, updated on the same edge as the valid bits, and range 0..DEPTH.
REQ-029 Without PIPE_REG_CNT_EN, port count and its logic SHALL be absent; all other behaviour is unchanged.

Verification (WIDTH=8, DEPTH=4)
REQ-030 Reset: rst=0 while in_valid=1, in_data=0xAA, clk toggling -> out_valid=0, out_data=0x00, count=0; first cycle after release in_ready=1.
REQ-031 Latency: send 0x11 on edge 0 with out_ready=1 -> out_valid=1 and out_data=0x11 after edge 3, then out_valid=0 after edge 4.
REQ-032 Backpressure: out_ready=0, send 0x01..0x05 -> 0x01..0x04 accepted, in_ready=0 on 5th attempt, count=4; raise out_ready -> outputs 0x01,0x02,0x03,0x04,0x05 in order, one per cycle.
REQ-033 Streaming: 100 consecutive items 0x00..0x63 with out_ready=1 -> all emerge in order on consecutive cycles, and in_ready stays 1 throughout.
REQ-034 Flush: full pipe 0x01..0x04 with flush=1, in_valid=1, in_data=0x55, out_ready=1 on one edge -> 0x01 transferred, next cycle out_valid=0, count=0, and 0x55 never emerges.
REQ-035 Async reset mid-stream: rst=0 pulse between edges with 3 items held -> out_valid=0 and count=0 immediately, no item emerges afterward.
